multiplier_scheduler: RTL

//  Shares one combinational single-carry array multiplier (module multiplier) between REQ clients.

---
 rtl/multiplier_scheduler_pkg.sv | 21 ++
 rtl/multiplier_scheduler_multiplier.sv | 21 ++
 rtl/multiplier_scheduler_rr_arbiter.sv | 24 ++
 rtl/multiplier_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/multiplier_scheduler_pkg.sv
// Shared types and helpers for the multiplier scheduler slice.
package multiplier_scheduler_pkg;

  // Scheduler FSM encodings; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time width calculations (clog2(1) == 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplier_scheduler_multiplier.sv
// Combinational unsigned array multiplier: one ripple-carry adder row per
// multiplier bit, each adding the shifted multiplicand when that bit is set.
module multiplier #(
  parameter int n = 16
) (
  input  logic [n-1:0]   m,
  input  logic [n-1:0]   q,
  output logic [2*n-1:0] sum
);

  logic [2*n-1:0] row [0:n];

  assign row[0] = '0;

  for (genvar i = 0; i < n; i++) begin : g_row
    assign row[i+1] = row[i] + (q[i] ? ((2*n)'(m) << i) : '0);
  end

  assign sum = row[n];

endmodule

// File: rtl/multiplier_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// above ptr, wrapping to the lowest requester when none are above.
module rr_arbiter #(
  parameter int REQ   = 4,
  parameter int PTR_W = 2
) (
  input  logic [REQ-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ-1:0]   grant
);

  logic [REQ-1:0] upper_mask;
  logic [REQ-1:0] upper_req;
  logic [REQ-1:0] pick;

  // Prefer requests at or above ptr; isolate the lowest set bit of the chosen set.
  always_comb begin
    upper_mask = ~((REQ'(1) << ptr) - REQ'(1));
    upper_req  = req & upper_mask;
    pick       = (|upper_req) ? upper_req : req;
    grant      = pick & (~pick + REQ'(1));
  end

endmodule

// File: rtl/multiplier_scheduler.sv
// Shares one combinational array multiplier between REQ clients. Round-robin
// grant, operands held SETTLE cycles (multicycle path m_r/q_r -> rsp_sum), product
// registered and held until the owning client accepts it. One op in flight.
import multiplier_scheduler_pkg::*;

module multiplier_scheduler #(
  parameter int N      = 16,
  parameter int REQ    = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ*N-1:0] req_m,
  input  logic [REQ*N-1:0] req_q,
  output logic [REQ-1:0]   rsp_valid,
  input  logic [REQ-1:0]   rsp_ready,
  output logic [2*N-1:0]   rsp_sum,
  output logic             busy
);

  localparam int PTR_W = (clog2(REQ) > 0) ? clog2(REQ) : 1;
  localparam int CNT_W = clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] settle_cnt;
  logic [N-1:0]     m_r;
  logic [N-1:0]     q_r;

  logic [REQ-1:0]   grant;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [N-1:0]     m_sel;
  logic [N-1:0]     q_sel;
  logic [2*N-1:0]   product;
  logic             req_hs;
  logic             rsp_hs;

  rr_arbiter #(
    .REQ   (REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  multiplier #(
    .n (N)
  ) u_mul (
    .m   (m_r),
    .q   (q_r),
    .sum (product)
  );

  // Grants are only offered while idle; one-hot so at most one handshake fires.
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign req_hs    = |(req_valid & req_ready);
  // rsp_valid is one-hot on the owner, so non-owner rsp_ready bits drop out here.
  assign rsp_hs    = |(rsp_valid & rsp_ready);
  assign ptr_next  = (gnt_idx == PTR_W'(REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Encode the granted client and mux out its operand slices.
  always_comb begin
    gnt_idx = '0;
    m_sel   = '0;
    q_sel   = '0;
    for (int i = 0; i < REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = PTR_W'(i);
        m_sel   = req_m[i*N +: N];
        q_sel   = req_q[i*N +: N];
      end
    end
  end

  // Scheduler FSM: accept an op, let the array settle, then hold the product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      settle_cnt <= '0;
      m_r        <= '0;
      q_r        <= '0;
      rsp_sum    <= '0;
      rsp_valid  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            m_r        <= m_sel;
            q_r        <= q_sel;
            owner      <= gnt_idx;
            rr_ptr     <= ptr_next;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
          if (settle_cnt == SETTLE_LAST) begin
            rsp_sum   <= product;
            rsp_valid <= REQ'(1) << owner;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
